// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch sequencer: FSM state encoding and display codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_OVF   = 3'd4
  } state_t;

  localparam logic [3:0]  DIG_DASH  = 4'hA;
  localparam logic [3:0]  DIG_BLANK = 4'hB;
  localparam logic [15:0] CNT_MAX   = 16'h9999;

endpackage

// File: rtl/bcd_digit_cnt.sv
// Mod-10 BCD digit counter; chain carry -> inc of the next digit for a same-cycle ripple.
// Latency: q updates on the edge where inc is high; carry is combinational (inc & q==9).
// Backpressure: none. Ports: clk, clr (async reset), zero (sync clear), inc, q[3:0], carry.
module bcd_digit_cnt (
  input  logic       clk,
  input  logic       clr,
  input  logic       zero,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == 4'd9);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 4'd0;
    end else if (zero) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: SS.CC BCD count with start/pause/lap/zero FSM feeding a 4-digit display.
// Latency: outputs are combinational decodes of registered state/count (no pipeline).
// Backpressure: none; button pulses are single-cycle, lower-priority ones in the same cycle are dropped.
// Ports: clk, clr (async, active-high), start_stop/lap/zero pulses, x[15:0] digits, running, ovf.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        zero,
  output logic [15:0] x,
  output logic        running,
  output logic        ovf
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  logic [15:0]   count;
  logic [15:0]   snap;
  logic          snap_cap;
  logic          active;
  logic          tick;
  logic          at_max;
  logic [3:0]    inc_chain;
  logic          carry_top_unused;

  assign active = (state == ST_RUN) || (state == ST_LAP);
  assign tick   = active && (presc == PRESC_LAST);
  assign at_max = (count == CNT_MAX);

  // Increments are suppressed at 99.99 so the count parks there once OVF is entered.
  assign inc_chain[0] = tick && !at_max;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    logic carry_i;
    bcd_digit_cnt u_digit (
      .clk   (clk),
      .clr   (clr),
      .zero  (zero),
      .inc   (inc_chain[i]),
      .q     (count[4*i +: 4]),
      .carry (carry_i)
    );
    if (i < 3) begin : g_link
      assign inc_chain[i+1] = carry_i;
    end else begin : g_top
      assign carry_top_unused = carry_i;
    end
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; overflow outranks start_stop/lap in RUN and LAP.
  always_comb begin
    state_nx = state;
    snap_cap = 1'b0;
    if (zero) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start_stop) state_nx = ST_RUN;
        ST_PAUSE: if (start_stop) state_nx = ST_RUN;
        ST_RUN: begin
          if (tick && at_max) begin
            state_nx = ST_OVF;
          end else if (start_stop) begin
            state_nx = ST_PAUSE;
          end else if (lap) begin
            state_nx = ST_LAP;
            snap_cap = 1'b1;
          end
        end
        ST_LAP: begin
          if (tick && at_max)  state_nx = ST_OVF;
          else if (start_stop) state_nx = ST_PAUSE;
          else if (lap)        state_nx = ST_RUN;
        end
        ST_OVF:   state_nx = ST_OVF;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Prescaler holds outside RUN/LAP so a resume keeps the partial tick; the snapshot
  // takes the registered (pre-increment) count even when a tick lands on the lap edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc <= '0;
      snap  <= '0;
    end else if (zero) begin
      presc <= '0;
      snap  <= '0;
    end else begin
      if (state == ST_IDLE) begin
        presc <= '0;
      end else if (active) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (snap_cap) begin
        snap <= count;
      end
    end
  end

  // Output decode
  always_comb begin
    logic [15:0] disp;
    running = active;
    ovf     = (state == ST_OVF);
    disp    = (state == ST_LAP) ? snap : count;
    if (state == ST_OVF) begin
      x = {4{DIG_DASH}};
    end else begin
      x = disp;
      if (BLANK_LZ && (disp[15:12] == 4'd0)) begin
        x[15:12] = DIG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4, BLANK_LZ=1.
// Latency: n/a. Backpressure: n/a.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;
  localparam int M_OVF   = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        zero = 1'b0;
  logic [15:0] x;
  logic        running;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  // Reference model: count kept as an integer number of centiseconds.
  int m_mode = M_IDLE;
  int m_cs   = 0;
  int m_snap = 0;
  int m_ph   = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .BLANK_LZ(1'b1)) dut (
    .clk        (clk),
    .clr        (clr),
    .start_stop (start_stop),
    .lap        (lap),
    .zero       (zero),
    .x          (x),
    .running    (running),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_x();
    int v;
    logic [15:0] r;
    if (m_mode == M_OVF) return 16'hAAAA;
    v = (m_mode == M_LAP) ? m_snap : m_cs;
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    if (v < 1000) r[15:12] = 4'hB;
    return r;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_mode = M_IDLE; m_cs = 0; m_snap = 0; m_ph = 0;
    end else if (zero) begin
      m_mode = M_IDLE; m_cs = 0; m_snap = 0; m_ph = 0;
    end else begin : upd
      bit act, tk, over;
      int old;
      act  = (m_mode == M_RUN) || (m_mode == M_LAP);
      tk   = act && (m_ph == TD - 1);
      over = tk && (m_cs == 9999);
      if (act) m_ph = tk ? 0 : m_ph + 1;
      old = m_cs;
      if (tk && !over) m_cs = m_cs + 1;
      case (m_mode)
        M_IDLE:  if (start_stop) m_mode = M_RUN;
        M_PAUSE: if (start_stop) m_mode = M_RUN;
        M_RUN: begin
          if (over) m_mode = M_OVF;
          else if (start_stop) m_mode = M_PAUSE;
          else if (lap) begin m_snap = old; m_mode = M_LAP; end
        end
        M_LAP: begin
          if (over) m_mode = M_OVF;
          else if (start_stop) m_mode = M_PAUSE;
          else if (lap) m_mode = M_RUN;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!clr) begin
      chk("model_x", {16'h0, x}, {16'h0, exp_x()});
      chk("model_running", {31'h0, running}, {31'h0, (m_mode == M_RUN) || (m_mode == M_LAP)});
      chk("model_ovf", {31'h0, ovf}, {31'h0, m_mode == M_OVF});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit z, input bit s, input bit l);
    zero = z; start_stop = s; lap = l;
    step(1);
    zero = 1'b0; start_stop = 1'b0; lap = 1'b0;
  endtask

  initial begin
    // Reset state
    step(1);
    chk("reset_x", {16'h0, x}, 32'hB000);
    chk("reset_running", {31'h0, running}, 32'h0);
    chk("reset_ovf", {31'h0, ovf}, 32'h0);
    clr = 1'b0;
    step(1);

    // First tick lands TICK_DIV edges after the start edge
    pulse(0, 1, 0);
    chk("start_running", {31'h0, running}, 32'h1);
    step(3);
    chk("pre_first_tick", {16'h0, x}, 32'hB000);
    step(1);
    chk("first_tick", {16'h0, x}, 32'hB001);
    step(399 * TD);
    chk("tick_400", {16'h0, x}, 32'hB400);

    // Pause with prescaler holding 2, resume picks up the partial tick
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    step(1);
    pulse(0, 1, 0);
    chk("paused_running", {31'h0, running}, 32'h0);
    step(100);
    chk("paused_hold", {16'h0, x}, 32'hB000);
    pulse(0, 1, 0);
    step(1);
    chk("resume_plus1", {16'h0, x}, 32'hB000);
    step(1);
    chk("resume_plus2", {16'h0, x}, 32'hB001);

    // Lap freeze at 12.34, release after 10 more ticks
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    step(1234 * TD);
    chk("live_1234", {16'h0, x}, 32'h1234);
    pulse(0, 0, 1);
    step(10 * TD);
    chk("lap_frozen", {16'h0, x}, 32'h1234);
    chk("lap_running", {31'h0, running}, 32'h1);
    pulse(0, 0, 1);
    chk("lap_release", {16'h0, x}, 32'h1244);

    // Overflow: reach 99.99 then one more tick
    begin
      int n = 0;
      while (x !== 16'h9999 && n < 40000) begin
        step(1);
        n++;
      end
      chk("reach_9999", {16'h0, x}, 32'h9999);
    end
    step(TD);
    chk("ovf_flag", {31'h0, ovf}, 32'h1);
    chk("ovf_x", {16'h0, x}, 32'hAAAA);
    pulse(0, 1, 0);
    step(TD);
    chk("ovf_ss_ignored", {16'h0, x}, 32'hAAAA);
    pulse(1, 0, 0);
    chk("zero_from_ovf", {16'h0, x}, 32'hB000);
    chk("zero_from_ovf_flag", {31'h0, ovf}, 32'h0);

    // zero and start_stop together from RUN
    pulse(0, 1, 0);
    step(9);
    chk("pre_zero_count", {16'h0, x}, 32'hB002);
    pulse(1, 1, 0);
    chk("zero_ss_x", {16'h0, x}, 32'hB000);
    chk("zero_ss_running", {31'h0, running}, 32'h0);

    // Asynchronous clear mid-prescaler in LAP
    pulse(0, 1, 0);
    step(6);
    pulse(0, 0, 1);
    step(1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_x", {16'h0, x}, 32'hB000);
    chk("clr_running", {31'h0, running}, 32'h0);
    chk("clr_ovf", {31'h0, ovf}, 32'h0);
    step(1);
    clr = 1'b0;
    step(1);

    // Random pulses against the model
    for (int i = 0; i < 4000; i++) begin
      zero       = ($urandom_range(199) == 0);
      start_stop = ($urandom_range(19) == 0);
      lap        = ($urandom_range(14) == 0);
      step(1);
    end
    zero = 1'b0; start_stop = 1'b0; lap = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch sequencer that drives the 16-bit digit vector `x` of the 4-digit seven-segment display driver. It counts SS.CC (seconds.centiseconds, 00.00–99.99) from the 100 MHz board clock. It runs a start/pause/lap/zero state machine and substitutes dash/blank codes for overflow and leading-zero suppression. It sits between the debounced button pulses and the display driver; the display's decimal point already falls between seconds and centiseconds.

## Interface
- `TICK_DIV`, 1_000_000: clk cycles per centisecond tick (100 MHz → 100 Hz); minimum 2.
- `BLANK_LZ`, 1: when 1, a zero tens-of-seconds digit is shown as blank code 4'hB.
- `clk`  in  1: system clock, 100 MHz.
- `clr`  in  1: reset, asynchronous, active-high; returns everything to IDLE.
- `start_stop`  in  1: single-cycle pulse, already debounced; toggles run/pause.
- `lap`  in  1: single-cycle pulse; freezes/unfreezes the displayed value while counting continues.
- `zero`  in  1: single-cycle pulse; clears the count and returns to IDLE.
- `x`  out  16: display digits {tens_s, units_s, tenths, hundredths}, one nibble each, BCD or code.
- `running`  out  1: high in RUN and LAP.
- `ovf`  out  1: high in OVF.

## Operation
- States: IDLE, RUN, PAUSE, LAP, OVF.
- Input priority per cycle: `zero` > `start_stop` > `lap`; lower-priority pulses in the same cycle are dropped.
- `zero` from any state → IDLE. It clears the count, snapshot and prescaler.
- IDLE: `start_stop` → RUN; `lap` ignored.
- RUN: `start_stop` → PAUSE. `lap` → LAP and captures the snapshot from the live count. A tick at 99.99 → OVF.
- LAP: `start_stop` → PAUSE (display returns to live). `lap` → RUN (live). A tick at 99.99 → OVF.
- PAUSE: `start_stop` → RUN; `lap` ignored.
- OVF: only `zero` exits. The count holds at 99.99 internally.
- Prescaler: counts 0..TICK_DIV-1 only in RUN/LAP. It holds its value in PAUSE, so a resume loses no partial tick. It is cleared in IDLE.
- Tick: prescaler == TICK_DIV-1 while in RUN/LAP. On a tick the prescaler wraps to 0.
- Count: four cascaded BCD digits, carry ripples same cycle.
  - hundredths 9→0 carries to tenths.
  - tenths 9→0 carries to units_s.
  - units_s 9→0 carries to tens_s.
  - Every digit stays in 0..9; no binary value 10–15 ever appears in a count nibble.
- `x` source:
  - OVF: 16'hAAAA (all dashes).
  - LAP: snapshot.
  - Otherwise: live count.
  - Then, if BLANK_LZ and x[15:12]==0 and not OVF, x[15:12] = 4'hB.

## Timing
- Reset values: state IDLE, count 0, snapshot 0, prescaler 0. Outputs `x` = 16'hB000 (BLANK_LZ=1) or 16'h0000, `running` 0, `ovf` 0.
- `x`, `running` and `ovf` are decoded combinationally from registered state and count, with no extra pipeline.
- The state changes on the clk edge that samples the pulse; outputs reflect it immediately after that edge.
- First tick after IDLE→RUN at edge E: the count becomes 00.01 at edge E+TICK_DIV.
- The count updates on the edge where tick is high; `x` shows the new value after that edge.
- A tick and `start_stop` in the same cycle from RUN: the tick is applied (count increments), then the state enters PAUSE.
- A tick and `lap` in the same cycle: the snapshot captures the pre-increment count.
- A tick at 99.99 and `start_stop` in the same cycle: OVF wins; `start_stop` is dropped.
- `zero` in the same cycle as a tick: the clear wins.
- `clr` mid-count: immediate asynchronous return to reset values, with no partial-tick carryover.

## Structure
- Shared package `stopwatch_pkg`:
  - state enum encoding;
  - `DIG_DASH` = 4'hA, `DIG_BLANK` = 4'hB;
  - `CNT_MAX` = 16'h9999.
- Sub-module `bcd_digit_cnt`: mod-10 counter with `clk`, `clr`, `zero`, `inc`, `q[3:0]` and `carry` (= inc & q==9). It is instanced four times, chained carry→inc.
- The top level holds the FSM, prescaler, snapshot register and output mux.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then `start_stop`, then 4 cycles → x=16'hB001. After 400 ticks total → x=16'h0400 with BLANK_LZ=0, or 16'hB400 with BLANK_LZ=1.
- RUN, then `start_stop` with the prescaler at 2; wait 100 cycles; then `start_stop` → x unchanged while paused, and the next increment occurs 2 cycles after resume.
- RUN to 12.34, then `lap` → x frozen at 12.34 while `running`=1. After 10 more ticks, `lap` → x=12.44.
- Run to 99.99, then one more tick → `ovf`=1, x=16'hAAAA, `start_stop` ignored. Then `zero` → IDLE, x=16'hB000.
- Assert `zero` and `start_stop` in the same cycle from RUN → IDLE, count 0, `running`=0.
- Assert `clr` asynchronously mid-prescaler in LAP → all outputs at reset values within the same cycle.
